// File: rtl/pc_increment_sequencer_if.sv
// Address-bus stage interface for pc_increment_sequencer.
// Carries the sequence request and jump-load inputs together with the driven address,
// register views and status pulses.
//   master : the controller side (drives start/pc_load/pc_load_val, observes the rest)
//   slave  : the sequencer itself
interface pc_increment_sequencer_if #(
  parameter int unsigned ADDR_WIDTH = 16
);
  logic                  start;
  logic                  pc_load;
  logic [ADDR_WIDTH-1:0] pc_load_val;
  logic [ADDR_WIDTH-1:0] addr_bus;
  logic                  addr_drive;
  logic [ADDR_WIDTH-1:0] pc;
  logic [ADDR_WIDTH-1:0] inc_reg;
  logic                  busy;
  logic                  done;
  logic                  wrap;

  modport master (
    output start,
    output pc_load,
    output pc_load_val,
    input  addr_bus,
    input  addr_drive,
    input  pc,
    input  inc_reg,
    input  busy,
    input  done,
    input  wrap
  );

  modport slave (
    input  start,
    input  pc_load,
    input  pc_load_val,
    output addr_bus,
    output addr_drive,
    output pc,
    output inc_reg,
    output busy,
    output done,
    output wrap
  );
endinterface

// File: rtl/pc_increment_sequencer.sv
// PC increment sequencer: upstream stage of the address bus.
// Owns the PC and INC registers and the INC16 incrementer, and runs the relay-style
// sequence drive PC -> latch PC+1 into INC -> drive INC -> latch INC into PC.
// Each drive phase is held SETTLE_CYCLES cycles to model contact settling.
// A direct PC load (jump target) is accepted while idle.
// Ports:
//   clk  : system clock, all state on rising edge
//   rst  : synchronous active-high reset
//   bus  : slave modport of pc_increment_sequencer_if
//          start/pc_load/pc_load_val in; addr_bus/addr_drive/pc/inc_reg/busy/done/wrap out
module pc_increment_sequencer #(
  parameter int unsigned ADDR_WIDTH    = 16,
  parameter int unsigned SETTLE_CYCLES = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  pc_increment_sequencer_if.slave  bus
);

  // Zero-length settle makes the drive phases meaningless; refuse to elaborate.
  if (SETTLE_CYCLES < 1) begin : gen_settle_check
    $fatal(1, "pc_increment_sequencer: SETTLE_CYCLES must be >= 1");
  end

  localparam int unsigned CntW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [CntW-1:0] CntLoad = CntW'(SETTLE_CYCLES - 1);

  typedef enum logic [2:0] {
    StIdle,
    StDrivePc,
    StLatchInc,
    StDriveInc,
    StLatchPc
  } state_e;

  state_e state_q, state_d;

  logic [CntW-1:0]       cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0] pc_q, pc_d;
  logic [ADDR_WIDTH-1:0] inc_q, inc_d;
  logic                  carry_q, carry_d;
  logic                  done_q, done_d;
  logic                  wrap_q, wrap_d;

  logic [ADDR_WIDTH-1:0] addr_bus;
  logic                  addr_drive;
  logic [ADDR_WIDTH:0]   inc_sum;

  // Load has priority over start in IDLE; both are ignored in any other state.
  logic idle_load, idle_start;
  assign idle_load  = (state_q == StIdle) && bus.pc_load;
  assign idle_start = (state_q == StIdle) && !bus.pc_load && bus.start;

  // Incrementer works on the driven bus value; the extra bit is the carry used only for wrap.
  assign inc_sum = {1'b0, addr_bus} + {{ADDR_WIDTH{1'b0}}, 1'b1};

  // ---------------------------------------------------------------------------
  // FSM state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (idle_start) begin
          state_d = StDrivePc;
        end
      end
      StDrivePc: begin
        if (cnt_q == '0) begin
          state_d = StLatchInc;
        end
      end
      StLatchInc: begin
        state_d = StDriveInc;
      end
      StDriveInc: begin
        if (cnt_q == '0) begin
          state_d = StLatchPc;
        end
      end
      StLatchPc: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM outputs: bus drive is a pure function of state, forced to 0 when idle
  // ---------------------------------------------------------------------------
  always_comb begin
    addr_drive = 1'b0;
    addr_bus   = '0;
    unique case (state_q)
      StDrivePc, StLatchInc: begin
        addr_drive = 1'b1;
        addr_bus   = pc_q;
      end
      StDriveInc, StLatchPc: begin
        addr_drive = 1'b1;
        addr_bus   = inc_q;
      end
      default: begin
        addr_drive = 1'b0;
        addr_bus   = '0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath next-state: settle counter, PC, INC, carry and status pulses
  // ---------------------------------------------------------------------------
  always_comb begin
    cnt_d   = cnt_q;
    pc_d    = pc_q;
    inc_d   = inc_q;
    carry_d = carry_q;
    done_d  = 1'b0;
    wrap_d  = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (idle_load) begin
          pc_d = bus.pc_load_val;
        end else if (idle_start) begin
          cnt_d = CntLoad;
        end
      end
      StDrivePc, StDriveInc: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      StLatchInc: begin
        inc_d   = inc_sum[ADDR_WIDTH-1:0];
        carry_d = inc_sum[ADDR_WIDTH];
        cnt_d   = CntLoad;
      end
      StLatchPc: begin
        pc_d   = inc_q;
        done_d = 1'b1;
        // Carry out of the incrementer is set exactly when INC rolled over to 0.
        wrap_d = carry_q;
      end
      default: begin
        cnt_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q   <= '0;
      pc_q    <= '0;
      inc_q   <= '0;
      carry_q <= 1'b0;
      done_q  <= 1'b0;
      wrap_q  <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      pc_q    <= pc_d;
      inc_q   <= inc_d;
      carry_q <= carry_d;
      done_q  <= done_d;
      wrap_q  <= wrap_d;
    end
  end

  assign bus.addr_bus   = addr_bus;
  assign bus.addr_drive = addr_drive;
  assign bus.pc         = pc_q;
  assign bus.inc_reg    = inc_q;
  assign bus.busy       = (state_q != StIdle);
  assign bus.done       = done_q;
  assign bus.wrap       = wrap_q;

endmodule
